// File: rtl/mul_seq_add.sv
// Sequential shift-and-add multiplier. It handles N-bit x by M-bit y for naturals or
// two's-complement integers and returns an (N+M)-bit product through the soc/eoc handshake.
module mul_seq_add #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             soc,
    input  logic             mode,
    input  logic [N-1:0]     x,
    input  logic [M-1:0]     y,
    output logic             eoc,
    output logic [N+M-1:0]   m
);

    localparam int W  = N + M;
    localparam int CW = $clog2(M + 1);

    localparam logic [CW-1:0] CNT_INIT = CW'(M);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [W-1:0]  W_ONE    = W'(1);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            eoc_q, eoc_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    xr_q, xr_d;
    logic [M-1:0]    qr_q, qr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            sign_q, sign_d;

    // The most-negative value negates to itself, and that bit pattern read as natural is the magnitude.
    function automatic logic [N-1:0] mag_x(input logic [N-1:0] v, input logic signed_mode);
        return (signed_mode & v[N-1]) ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [M-1:0] mag_y(input logic [M-1:0] v, input logic signed_mode);
        return (signed_mode & v[M-1]) ? (~v + {{(M-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Next-state and datapath logic for the start / shift-add / sign-fix / release sequence.
    always_comb begin
        state_d = state_q;
        eoc_d   = eoc_q;
        m_d     = m_q;
        acc_d   = acc_q;
        xr_d    = xr_q;
        qr_d    = qr_q;
        count_d = count_q;
        sign_d  = sign_q;
        case (state_q)
            S0: begin
                if (soc) begin
                    xr_d    = {{M{1'b0}}, mag_x(x, mode)};
                    qr_d    = mag_y(y, mode);
                    acc_d   = {W{1'b0}};
                    count_d = CNT_INIT;
                    sign_d  = mode & (x[N-1] ^ y[M-1]);
                    eoc_d   = 1'b0;
                    state_d = S1;
                end else begin
                    state_d = S0;
                end
            end
            S1: begin
                if (qr_q[0]) begin
                    acc_d = acc_q + xr_q;
                end else begin
                    acc_d = acc_q;
                end
                xr_d    = xr_q << 1;
                qr_d    = qr_q >> 1;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S2;
                end else begin
                    state_d = S1;
                end
            end
            S2: begin
                // Negating a zero magnitude wraps back to zero, so no negative zero can appear.
                m_d     = sign_q ? (~acc_q + W_ONE) : acc_q;
                state_d = S3;
            end
            S3: begin
                if (!soc) begin
                    eoc_d   = 1'b1;
                    state_d = S0;
                end else begin
                    state_d = S3;
                end
            end
            default: begin
                eoc_d   = 1'b1;
                state_d = S0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S0;
            eoc_q   <= 1'b1;
            m_q     <= {W{1'b0}};
            acc_q   <= {W{1'b0}};
            xr_q    <= {W{1'b0}};
            qr_q    <= {M{1'b0}};
            count_q <= {CW{1'b0}};
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eoc_q   <= eoc_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            xr_q    <= xr_d;
            qr_q    <= qr_d;
            count_q <= count_d;
            sign_q  <= sign_d;
        end
    end

    assign eoc = eoc_q;
    assign m   = m_q;

endmodule

// File: tb/tb_mul_seq_add.sv
// Directed self-checking bench for mul_seq_add with N=M=8. The bench drives and samples on
// the falling clock edge.
module tb_mul_seq_add;

    logic        clock;
    logic        reset_;
    logic        soc;
    logic        mode;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        eoc;
    logic [15:0] m;

    int n_asserts = 0;
    int n_fail    = 0;
    int edges;

    mul_seq_add #(.N(8), .M(8)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .mode   (mode),
        .x      (x),
        .y      (y),
        .eoc    (eoc),
        .m      (m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raises soc for exactly one rising edge (edge 0). The task returns at the falling edge after it.
    task automatic start_op(input logic md, input logic [7:0] xv, input logic [7:0] yv);
        mode = md;
        x    = xv;
        y    = yv;
        soc  = 1'b1;
        @(negedge clock);
        soc  = 1'b0;
    endtask

    // Counts rising edges after edge 0 until eoc is high. The wait is bounded at 40 edges.
    task automatic wait_eoc(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (eoc) break;
        end
    endtask

    initial begin
        reset_ = 1'b1;
        soc    = 1'b0;
        mode   = 1'b0;
        x      = 8'h00;
        y      = 8'h00;
        #2 reset_ = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_eoc", {31'd0, eoc}, 32'd1);
        check("reset_m", {16'd0, m}, 32'd0);
        reset_ = 1'b1;
        @(negedge clock);

        // Naturals: 255 * 255
        start_op(1'b0, 8'd255, 8'd255);
        check("nat_eoc_low", {31'd0, eoc}, 32'd0);
        wait_eoc(edges);
        check("nat_latency", edges, 32'd10);
        check("nat_m", {16'd0, m}, 32'h0000_FE01);

        // Integers: -128 * -128
        start_op(1'b1, 8'h80, 8'h80);
        wait_eoc(edges);
        check("int_neg_neg_latency", edges, 32'd10);
        check("int_neg_neg_m", {16'd0, m}, 32'h0000_4000);

        // Integers: -128 * 127
        start_op(1'b1, 8'h80, 8'h7F);
        wait_eoc(edges);
        check("int_neg_pos_m", {16'd0, m}, 32'h0000_C080);

        // Integers: 0 * -5 must not produce a negative zero
        start_op(1'b1, 8'h00, 8'hFB);
        wait_eoc(edges);
        check("int_zero_m", {16'd0, m}, 32'h0000_0000);

        // Handshake hold: soc stays high while the operands change mid-operation
        mode = 1'b0;
        x    = 8'd3;
        y    = 8'd4;
        soc  = 1'b1;
        @(negedge clock);
        x    = 8'hFF;
        y    = 8'hFF;
        mode = 1'b1;
        repeat (9) @(negedge clock);
        check("hold_m_edge9", {16'd0, m}, 32'd12);
        check("hold_eoc_edge9", {31'd0, eoc}, 32'd0);
        repeat (11) @(negedge clock);
        check("hold_eoc_held", {31'd0, eoc}, 32'd0);
        check("hold_m_stable", {16'd0, m}, 32'd12);
        soc = 1'b0;
        @(negedge clock);
        check("hold_eoc_release", {31'd0, eoc}, 32'd1);
        check("hold_m_release", {16'd0, m}, 32'd12);

        // Reset mid-operation, asserted away from any clock edge
        start_op(1'b0, 8'd200, 8'd100);
        repeat (3) @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        check("midrst_eoc", {31'd0, eoc}, 32'd1);
        check("midrst_m", {16'd0, m}, 32'd0);
        @(negedge clock);
        check("midrst_held_eoc", {31'd0, eoc}, 32'd1);
        reset_ = 1'b1;
        @(negedge clock);
        start_op(1'b0, 8'd7, 8'd9);
        wait_eoc(edges);
        check("post_rst_latency", edges, 32'd10);
        check("post_rst_m", {16'd0, m}, 32'd63);

        // Back-to-back: -3 * 5, then 10 * 20
        start_op(1'b1, 8'hFD, 8'd5);
        wait_eoc(edges);
        check("b2b_first_m", {16'd0, m}, 32'h0000_FFF1);
        start_op(1'b0, 8'd10, 8'd20);
        repeat (8) @(negedge clock);
        check("b2b_m_hold_s1", {16'd0, m}, 32'h0000_FFF1);
        check("b2b_eoc_busy", {31'd0, eoc}, 32'd0);
        @(negedge clock);
        check("b2b_second_m", {16'd0, m}, 32'd200);
        @(negedge clock);
        check("b2b_second_eoc", {31'd0, eoc}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
